// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_reg
// Brief    : MEM->WB pipeline register with valid/ready handshake, optional
//            skid entry (MEM_WB_PIPE_REG_SKID_EN) and write-back data select.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] data_memory_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] data_memory_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [1:0]        occupancy
);

    localparam int C_PW = 2 + 2 * DATA_W + DEST_W;

    logic [C_PW-1:0] w_in_beat;
    logic [C_PW-1:0] r_main;
    logic            r_main_valid;
    logic            w_accept;
    logic            w_deliver;
    logic            w_main_wb_en;
    logic            w_main_mem_r_en;

    assign w_in_beat = {wb_en_in, mem_r_en_in, alu_res_in, data_memory_in, dest_in};
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_main_valid & out_ready;

`ifdef MEM_WB_PIPE_REG_SKID_EN
    logic [C_PW-1:0] r_skid;
    logic            r_skid_valid;
    logic            r_in_ready;

    // The skid entry is only ever filled while main is full and stalled,
    // so it is always empty whenever main is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_deliver && r_skid_valid) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_deliver || !r_main_valid) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main <= w_in_beat;
            end
        end else if (w_accept) begin
            r_skid       <= w_in_beat;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= w_in_beat;
            r_main_valid <= 1'b1;
        end else if (w_deliver) begin
            r_main_valid <= 1'b0;
        end
    end

    // Single entry: room exists when empty or when it drains this edge.
    assign in_ready  = out_ready | ~r_main_valid;
    assign occupancy = {1'b0, r_main_valid};
`endif

    assign {w_main_wb_en, w_main_mem_r_en, alu_res_out, data_memory_out, dest_out} = r_main;

    assign out_valid    = r_main_valid;
    assign wb_en_out    = r_main_valid & w_main_wb_en;
    assign mem_r_en_out = r_main_valid & w_main_mem_r_en;
    assign wb_data_out  = mem_r_en_out ? data_memory_out : alu_res_out;

endmodule
`default_nettype wire
